// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the 5-stage MIPS core.
package pipe_pkg;

  localparam int ALU_OP_W = 2;

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = 2'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = 2'd1;
  localparam logic [ALU_OP_W-1:0] ALU_FUNCT = 2'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR    = 2'd3;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic alu_src;
    logic reg_dst;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector; purely combinational so the IF/ID register can share it.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic       reset,
  input  logic       ex_branch_taken,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       id_valid,
  input  logic       id_uses_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       hz,
  output logic       stall
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ex_rt == id_rs);
  assign rt_match = id_uses_rt & (ex_rt == id_rt);

  // A load into $zero never produces a value worth waiting for.
  assign hz = ex_valid & ex_mem_read & (ex_rt != REG_ZERO) & id_valid & (rs_match | rt_match);

  // A taken branch discards the dependent instruction, so flushing wins.
  assign stall = hz & ~ex_branch_taken & ~reset;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch squash and saturating debug counters.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int ALU_OP_W = pipe_pkg::ALU_OP_W,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hold,
  input  logic                ex_branch_taken,
  input  logic                id_valid,
  input  logic                id_uses_rt,
  input  logic [31:0]         id_pc_plus4,
  input  logic [31:0]         id_read_data1,
  input  logic [31:0]         id_read_data2,
  input  logic [4:0]          id_rs,
  input  logic [4:0]          id_rt,
  input  logic [4:0]          id_rd,
  input  logic [31:0]         id_imm_ext,
  input  logic                id_reg_write,
  input  logic                id_mem_to_reg,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic                id_branch,
  input  logic                id_alu_src,
  input  logic                id_reg_dst,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  output logic                stall,
  output logic                ex_valid,
  output logic [31:0]         ex_pc_plus4,
  output logic [31:0]         ex_read_data1,
  output logic [31:0]         ex_read_data2,
  output logic [31:0]         ex_imm_ext,
  output logic [4:0]          ex_rs,
  output logic [4:0]          ex_rt,
  output logic [4:0]          ex_rd,
  output logic                ex_reg_write,
  output logic                ex_mem_to_reg,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_branch,
  output logic                ex_alu_src,
  output logic                ex_reg_dst,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic [CNT_W-1:0]    stall_count,
  output logic [CNT_W-1:0]    flush_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  hz;
  logic  load_bubble;

  assign id_ctrl = '{reg_write:  id_reg_write,
                     mem_to_reg: id_mem_to_reg,
                     mem_read:   id_mem_read,
                     mem_write:  id_mem_write,
                     branch:     id_branch,
                     alu_src:    id_alu_src,
                     reg_dst:    id_reg_dst};

  hazard_detect u_hazard (
    .reset           (reset),
    .ex_branch_taken (ex_branch_taken),
    .ex_valid        (ex_valid),
    .ex_mem_read     (ex_ctrl.mem_read),
    .ex_rt           (ex_rt),
    .id_valid        (id_valid),
    .id_uses_rt      (id_uses_rt),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .hz              (hz),
    .stall           (stall)
  );

  assign load_bubble = ex_branch_taken | stall;

  always_ff @(posedge clk) begin
    if (reset || (!hold && load_bubble)) begin
      ex_valid      <= 1'b0;
      ex_ctrl       <= CTRL_BUBBLE;
      ex_pc_plus4   <= '0;
      ex_read_data1 <= '0;
      ex_read_data2 <= '0;
      ex_imm_ext    <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
      ex_alu_op     <= '0;
    end else if (!hold) begin
      ex_valid      <= id_valid;
      ex_ctrl       <= id_ctrl;
      ex_pc_plus4   <= id_pc_plus4;
      ex_read_data1 <= id_read_data1;
      ex_read_data2 <= id_read_data2;
      ex_imm_ext    <= id_imm_ext;
      ex_rs         <= id_rs;
      ex_rt         <= id_rt;
      ex_rd         <= id_rd;
      ex_alu_op     <= id_alu_op;
    end
  end

  // Only one of the two events is counted per edge: a flush masks the stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (!hold) begin
      if (ex_branch_taken) begin
        if (id_valid && flush_count != CNT_MAX) flush_count <= flush_count + CNT_ONE;
      end else if (stall) begin
        if (stall_count != CNT_MAX) stall_count <= stall_count + CNT_ONE;
      end
    end
  end

  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_branch     = ex_ctrl.branch;
  assign ex_alu_src    = ex_ctrl.alu_src;
  assign ex_reg_dst    = ex_ctrl.reg_dst;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver queues hand-computed expectations, the monitor checks them.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, hold, ex_branch_taken, id_valid, id_uses_rt;
  logic [31:0] id_pc_plus4, id_read_data1, id_read_data2, id_imm_ext;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_branch, id_alu_src, id_reg_dst;
  logic [1:0]  id_alu_op;

  logic        stall, ex_valid;
  logic [31:0] ex_pc_plus4, ex_read_data1, ex_read_data2, ex_imm_ext;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src, ex_reg_dst;
  logic [1:0]  ex_alu_op;
  logic [15:0] stall_count, flush_count;

  logic        s_stall, s_ex_valid;
  logic [31:0] s_ex_pc_plus4, s_ex_read_data1, s_ex_read_data2, s_ex_imm_ext;
  logic [4:0]  s_ex_rs, s_ex_rt, s_ex_rd;
  logic        s_ex_reg_write, s_ex_mem_to_reg, s_ex_mem_read, s_ex_mem_write, s_ex_branch, s_ex_alu_src, s_ex_reg_dst;
  logic [1:0]  s_ex_alu_op;
  logic [2:0]  s_stall_count, s_flush_count;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .hold(hold), .ex_branch_taken(ex_branch_taken),
    .id_valid(id_valid), .id_uses_rt(id_uses_rt), .id_pc_plus4(id_pc_plus4),
    .id_read_data1(id_read_data1), .id_read_data2(id_read_data2),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm_ext(id_imm_ext),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_branch(id_branch), .id_alu_src(id_alu_src),
    .id_reg_dst(id_reg_dst), .id_alu_op(id_alu_op),
    .stall(stall), .ex_valid(ex_valid), .ex_pc_plus4(ex_pc_plus4),
    .ex_read_data1(ex_read_data1), .ex_read_data2(ex_read_data2), .ex_imm_ext(ex_imm_ext),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_alu_src(ex_alu_src),
    .ex_reg_dst(ex_reg_dst), .ex_alu_op(ex_alu_op),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // Narrow-counter twin driven identically, so saturation is reachable in a short run.
  id_ex_stage #(.CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .hold(hold), .ex_branch_taken(ex_branch_taken),
    .id_valid(id_valid), .id_uses_rt(id_uses_rt), .id_pc_plus4(id_pc_plus4),
    .id_read_data1(id_read_data1), .id_read_data2(id_read_data2),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm_ext(id_imm_ext),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_branch(id_branch), .id_alu_src(id_alu_src),
    .id_reg_dst(id_reg_dst), .id_alu_op(id_alu_op),
    .stall(s_stall), .ex_valid(s_ex_valid), .ex_pc_plus4(s_ex_pc_plus4),
    .ex_read_data1(s_ex_read_data1), .ex_read_data2(s_ex_read_data2), .ex_imm_ext(s_ex_imm_ext),
    .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_rd(s_ex_rd),
    .ex_reg_write(s_ex_reg_write), .ex_mem_to_reg(s_ex_mem_to_reg), .ex_mem_read(s_ex_mem_read),
    .ex_mem_write(s_ex_mem_write), .ex_branch(s_ex_branch), .ex_alu_src(s_ex_alu_src),
    .ex_reg_dst(s_ex_reg_dst), .ex_alu_op(s_ex_alu_op),
    .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  typedef struct {
    string       nm;
    logic        st;
    logic        vld;
    logic [31:0] d1;
    logic [4:0]  rt;
    logic [1:0]  op;
    logic        rw;
    logic        mr;
    int          sc;
    int          fc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s got 0x%0h want 0x%0h", nm, f, act, exp);
    end
  endtask

  // Monitor: stall sampled just before the edge, registered outputs just after it.
  initial begin
    logic st_pre;
    exp_t e;
    forever begin
      @(negedge clk);
      #4 st_pre = stall;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.nm, "stall",     {31'd0, st_pre},        {31'd0, e.st});
        chk(e.nm, "ex_valid",  {31'd0, ex_valid},      {31'd0, e.vld});
        chk(e.nm, "rd1",       ex_read_data1,          e.d1);
        chk(e.nm, "ex_rt",     {27'd0, ex_rt},         {27'd0, e.rt});
        chk(e.nm, "alu_op",    {30'd0, ex_alu_op},     {30'd0, e.op});
        chk(e.nm, "reg_write", {31'd0, ex_reg_write},  {31'd0, e.rw});
        chk(e.nm, "mem_read",  {31'd0, ex_mem_read},   {31'd0, e.mr});
        chk(e.nm, "stall_cnt", {16'd0, stall_count},   e.sc);
        chk(e.nm, "flush_cnt", {16'd0, flush_count},   e.fc);
        chk(e.nm, "sat_cnt",   {29'd0, s_stall_count}, (e.sc > 7) ? 7 : e.sc);
      end
    end
  end

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                        input logic [31:0] d1, input logic mr, input logic rw, input logic [1:0] op);
    id_valid      = v;
    id_rs         = rs;
    id_rt         = rt;
    id_rd         = rs ^ rt;
    id_uses_rt    = ut;
    id_read_data1 = d1;
    id_read_data2 = ~d1;
    id_imm_ext    = d1 + 32'd4;
    id_pc_plus4   = d1 + 32'h400;
    id_mem_read   = mr;
    id_mem_to_reg = mr;
    id_reg_write  = rw;
    id_alu_op     = op;
    id_alu_src    = mr;
    id_reg_dst    = ~mr;
  endtask

  task automatic step(input string nm, input logic st, input logic vld, input logic [31:0] d1,
                      input logic [4:0] rt, input logic [1:0] op, input logic rw, input logic mr,
                      input int sc, input int fc);
    exp_t e;
    e = '{nm: nm, st: st, vld: vld, d1: d1, rt: rt, op: op, rw: rw, mr: mr, sc: sc, fc: fc};
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic bubble(input string nm, input logic st, input int sc, input int fc);
    step(nm, st, 1'b0, 32'd0, 5'd0, 2'd0, 1'b0, 1'b0, sc, fc);
  endtask

  initial begin
    int sc;
    reset = 1'b1; hold = 1'b0; ex_branch_taken = 1'b0;
    id_mem_write = 1'b0; id_branch = 1'b0;
    set_id(1, 5'd2, 5'd2, 1, 32'hDEAD, 1, 1, 2'd2);
    @(negedge clk);
    bubble("reset0", 0, 0, 0);
    bubble("reset1", 0, 0, 0);

    reset = 1'b0;
    set_id(1, 5'd1, 5'd4, 1, 32'h1, 0, 1, 2'd2);
    step("plain", 0, 1, 32'h1, 5'd4, 2'd2, 1, 0, 0, 0);

    set_id(1, 5'd1, 5'd2, 0, 32'h10, 1, 1, 2'd0);
    step("lw2", 0, 1, 32'h10, 5'd2, 2'd0, 1, 1, 0, 0);
    set_id(1, 5'd2, 5'd4, 1, 32'h20, 0, 1, 2'd2);
    bubble("lu_stall", 1, 1, 0);
    step("lu_add", 0, 1, 32'h20, 5'd4, 2'd2, 1, 0, 1, 0);

    set_id(1, 5'd1, 5'd0, 0, 32'h30, 1, 1, 2'd0);
    step("lw0", 0, 1, 32'h30, 5'd0, 2'd0, 1, 1, 1, 0);
    set_id(1, 5'd0, 5'd0, 1, 32'h40, 0, 1, 2'd2);
    step("zero_rd", 0, 1, 32'h40, 5'd0, 2'd2, 1, 0, 1, 0);

    set_id(1, 5'd1, 5'd5, 0, 32'h50, 1, 1, 2'd0);
    step("lw5", 0, 1, 32'h50, 5'd5, 2'd0, 1, 1, 1, 0);
    set_id(1, 5'd3, 5'd5, 0, 32'h60, 0, 1, 2'd0);
    step("addi_nort", 0, 1, 32'h60, 5'd5, 2'd0, 1, 0, 1, 0);

    set_id(1, 5'd1, 5'd6, 0, 32'h70, 1, 1, 2'd0);
    step("lw6", 0, 1, 32'h70, 5'd6, 2'd0, 1, 1, 1, 0);
    set_id(1, 5'd7, 5'd6, 1, 32'h80, 0, 0, 2'd2);
    bubble("rt_stall", 1, 2, 0);
    step("rt_enter", 0, 1, 32'h80, 5'd6, 2'd2, 0, 0, 2, 0);

    set_id(1, 5'd1, 5'd2, 0, 32'h90, 1, 1, 2'd0);
    step("lw2b", 0, 1, 32'h90, 5'd2, 2'd0, 1, 1, 2, 0);
    ex_branch_taken = 1'b1;
    set_id(1, 5'd2, 5'd4, 1, 32'hA0, 0, 1, 2'd2);
    bubble("br_flush", 0, 2, 1);
    ex_branch_taken = 1'b0;
    step("br_after", 0, 1, 32'hA0, 5'd4, 2'd2, 1, 0, 2, 1);

    hold = 1'b1;
    set_id(1, 5'd9, 5'd9, 1, 32'hB0, 1, 0, 2'd1);
    step("hold0", 0, 1, 32'hA0, 5'd4, 2'd2, 1, 0, 2, 1);
    set_id(0, 5'd8, 5'd7, 0, 32'hC0, 0, 0, 2'd3);
    step("hold1", 0, 1, 32'hA0, 5'd4, 2'd2, 1, 0, 2, 1);
    ex_branch_taken = 1'b1;
    set_id(1, 5'd6, 5'd5, 1, 32'hD0, 1, 1, 2'd1);
    step("hold_br0", 0, 1, 32'hA0, 5'd4, 2'd2, 1, 0, 2, 1);
    step("hold_br1", 0, 1, 32'hA0, 5'd4, 2'd2, 1, 0, 2, 1);
    hold = 1'b0;
    bubble("rel_flush", 0, 2, 2);
    ex_branch_taken = 1'b0;
    set_id(1, 5'd1, 5'd3, 1, 32'hE0, 0, 1, 2'd2);
    step("rel_after", 0, 1, 32'hE0, 5'd3, 2'd2, 1, 0, 2, 2);

    set_id(1, 5'd1, 5'd3, 0, 32'hF0, 1, 1, 2'd0);
    step("lw3", 0, 1, 32'hF0, 5'd3, 2'd0, 1, 1, 2, 2);
    hold = 1'b1;
    set_id(1, 5'd3, 5'd1, 1, 32'h11, 0, 1, 2'd2);
    step("hold_hz", 1, 1, 32'hF0, 5'd3, 2'd0, 1, 1, 2, 2);
    hold = 1'b0;
    bubble("hz_release", 1, 3, 2);
    step("hz_enter", 0, 1, 32'h11, 5'd1, 2'd2, 1, 0, 3, 2);

    sc = 3;
    for (int i = 0; i < 6; i++) begin
      set_id(1, 5'd1, 5'd2, 0, 32'h100 + i, 1, 1, 2'd0);
      step("sat_lw", 0, 1, 32'h100 + i, 5'd2, 2'd0, 1, 1, sc, 2);
      sc++;
      set_id(1, 5'd2, 5'd4, 1, 32'h200 + i, 0, 1, 2'd2);
      bubble("sat_stall", 1, sc, 2);
    end

    reset = 1'b1; hold = 1'b1;
    bubble("reset_hold", 0, 0, 0);
    reset = 1'b0; hold = 1'b0;

    repeat (3) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS core. Directly downstream of the register file.
- Captures readData1/readData2, the decoded control and the instruction fields, and presents them to EX one cycle later.
- Contains the load-use hazard detector:
  - generates the IF/ID stall;
  - inserts bubbles on stall;
  - squashes on a taken branch;
  - keeps saturating stall/flush counters for debug display.

Parameters:
- ALU_OP_W, 2, width of ALU operation code.
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge. The register file writes on negedge.
- reset  in  1  reset, synchronous, active-high.
- hold  in  1  global freeze (e.g. memory busy); all state holds.
- ex_branch_taken  in  1  EX resolved a taken branch; squash the instruction currently in ID.
- id_valid  in  1  ID holds a real instruction.
- id_uses_rt  in  1  ID instruction reads rt as a source (R-type, beq, sw).
- id_pc_plus4  in  32  PC+4 of the ID instruction.
- id_read_data1, id_read_data2  in  32  register file outputs.
- id_rs, id_rt, id_rd  in  5 each  instruction fields [25:21], [20:16], [15:11].
- id_imm_ext  in  32  sign-extended immediate.
- id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_branch, id_alu_src, id_reg_dst  in  1 each  decoded control.
- id_alu_op  in  ALU_OP_W  decoded ALU op.
- stall  out  1  combinational; holds PC and IF/ID this cycle.
- ex_valid  out  1  EX holds a real instruction.
- ex_pc_plus4, ex_read_data1, ex_read_data2, ex_imm_ext  out  32 each  registered copies.
- ex_rs, ex_rt, ex_rd  out  5 each  registered copies.
- ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src, ex_reg_dst  out  1 each  registered control.
- ex_alu_op  out  ALU_OP_W  registered ALU op.
- stall_count, flush_count  out  CNT_W  saturating event counters.

Behaviour:
- Reset:
  - takes effect at the posedge where reset=1;
  - all ex_* outputs and both counters go to 0 (ex_valid=0, a bubble);
  - stall is forced to 0 while reset=1;
  - reset overrides hold.
- Load-use hazard, combinational:
  - hz = ex_valid & ex_mem_read & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  - stall = hz & ~ex_branch_taken & ~reset.
- Per-posedge update, priority order:
  1. reset.
  2. hold=1: every register and counter unchanged. stall output still reflects hz.
  3. ex_branch_taken=1: load a bubble. flush_count += 1 if id_valid, saturating at all-ones.
  4. stall=1: load a bubble. stall_count += 1, saturating.
  5. Otherwise: load all id_* into ex_*. ex_valid <= id_valid.
- Bubble definition:
  - ex_valid=0;
  - ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_mem_to_reg = 0;
  - all other ex_* fields = 0.
- Latency:
  - one cycle ID->EX;
  - a load-use pair costs exactly one stall cycle, because the bubble clears ex_mem_read so hz drops the next cycle.
- Branch/hazard overlap: ex_branch_taken with hz true gives stall=0. Flush wins, since the dependent instruction is discarded.
- $zero: writes to register 0 never create a hazard (ex_rt != 0 term).
- Hold followed by release:
  - ex_branch_taken stays asserted because EX is frozen, so the flush is applied on the first non-hold edge;
  - the flush is counted once.
- Counters:
  - at all-ones they stay at all-ones;
  - not affected by hold;
  - cleared only by reset.
- No forwarding muxes here; those live in the downstream forwarding unit, which consumes ex_rs/ex_rt.

Decomposition:
- Shared package pipe_pkg:
  - ALU_OP_W;
  - ALU op encodings;
  - REG_ZERO = 5'd0;
  - a bubble constant for the control bundle.
- Sub-module hazard_detect: purely combinational computation of hz/stall, reusable by the IF/ID register.
- Counters and pipeline register stay in id_ex_stage.

Test Plan:
- Reset: reset=1 for 2 cycles with id_* driven nonzero. All ex_* = 0, stall = 0, counters = 0.
- Plain flow: id_valid=1, id_rs=1, id_read_data1=0x00000001, id_alu_op=2, no hazard. After 1 edge, ex_read_data1=0x00000001, ex_alu_op=2, ex_valid=1, stall=0.
- Load-use (lw $2 then add $3,$2,$4):
  - ex_mem_read=1, ex_rt=2, id_rs=2 gives stall=1 for one cycle;
  - next edge loads a bubble (ex_reg_write=0, ex_valid=0), stall_count=1;
  - following cycle stall=0 and the add enters EX.
- $zero and id_uses_rt=0: lw into $0 followed by a read of $0 gives stall=0. lw $5, then addi reading rt=5 with id_uses_rt=0 gives stall=0.
- Branch flush overlapping a hazard: ex_branch_taken=1 while hz true gives stall=0; next edge loads a bubble; flush_count=1, stall_count unchanged.
- Hold and saturation:
  - hold=1 for 3 cycles with changing id_*: ex_* unchanged;
  - force 65536 stalls: stall_count = 0xFFFF and stays there.
